// File: rtl/menu_select_fsm_if.sv
// Key-level inputs and menu status outputs exchanged between the keyboard/game
// side and the menu selection controller.
interface menu_select_fsm_if #(
   parameter int unsigned N_ITEMS = 3
);
   localparam int unsigned CW = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1;

   logic          w_press;
   logic          s_press;
   logic          enter_press;
   logic          game_over;
   logic [CW-1:0] cursor;
   logic [CW-1:0] mode;
   logic          start_pulse;
   logic          in_menu;

   modport master (
      output w_press, s_press, enter_press, game_over,
      input  cursor, mode, start_pulse, in_menu
   );

   modport slave (
      input  w_press, s_press, enter_press, game_over,
      output cursor, mode, start_pulse, in_menu
   );
endinterface

// File: rtl/menu_select_fsm.sv
// Menu navigation controller: synchronises PS/2 key levels, moves a wrapping
// cursor with hold-to-repeat, commits a selection and starts the game core.
module menu_select_fsm #(
   parameter int unsigned N_ITEMS       = 3,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 15_000_000
) (
   input logic              clk,
   input logic              rst,
   menu_select_fsm_if.slave bus
);
   localparam int unsigned CW = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1;
   localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);
   localparam logic [CW-1:0] LAST_ITEM = CW'(N_ITEMS - 1);

   typedef enum logic [1:0] {
      MENU     = 2'd0,
      WAIT_REL = 2'd1,
      RUN      = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    w_sync, s_sync, e_sync;  // [0]=d1, [1]=d2, [2]=d3 history
   logic [CW-1:0] cursor_q, cursor_d;
   logic [CW-1:0] mode_q, mode_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          start_q, start_d;
   logic          in_menu_q, in_menu_d;

   logic w_held, s_held, e_held;
   logic w_edge, s_edge, e_edge;

   assign w_held = w_sync[1];
   assign s_held = s_sync[1];
   assign e_held = e_sync[1];
   assign w_edge = w_sync[1] & ~w_sync[2];
   assign s_edge = s_sync[1] & ~s_sync[2];
   assign e_edge = e_sync[1] & ~e_sync[2];

   function automatic logic [CW-1:0] item_up(input logic [CW-1:0] c);
      return (c == '0) ? LAST_ITEM : c - CW'(1);
   endfunction

   function automatic logic [CW-1:0] item_down(input logic [CW-1:0] c);
      return (c == LAST_ITEM) ? '0 : c + CW'(1);
   endfunction

   // Next-state, cursor, selection and repeat-counter logic
   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      mode_d   = mode_q;
      hold_d   = hold_q;
      start_d  = 1'b0;

      unique case (state_q)
         MENU: begin
            hold_d = '0;
            if (e_edge) begin
               mode_d  = cursor_q;
               state_d = WAIT_REL;
            end else if (w_held && s_held) begin
               hold_d = '0;
            end else if (w_edge) begin
               cursor_d = item_up(cursor_q);
            end else if (s_edge) begin
               cursor_d = item_down(cursor_q);
            end else if (w_held || s_held) begin
               // Step on the cycle the count reaches REPEAT_DELAY, then re-arm
               // so later steps are REPEAT_PERIOD apart.
               if (hold_q == HW'(REPEAT_DELAY - 1)) begin
                  hold_d   = HW'(REPEAT_DELAY - REPEAT_PERIOD);
                  cursor_d = s_held ? item_down(cursor_q) : item_up(cursor_q);
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
         end
         WAIT_REL: begin
            hold_d = '0;
            if (!e_held) begin
               start_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            hold_d = '0;
            if (bus.game_over) begin
               cursor_d = mode_q;
               state_d  = MENU;
            end
         end
         default: begin
            hold_d  = '0;
            state_d = MENU;
         end
      endcase

      in_menu_d = (state_d != RUN);
   end

   // State, synchroniser and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MENU;
         w_sync    <= '0;
         s_sync    <= '0;
         e_sync    <= '0;
         cursor_q  <= '0;
         mode_q    <= '0;
         hold_q    <= '0;
         start_q   <= 1'b0;
         in_menu_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         w_sync    <= {w_sync[1:0], bus.w_press};
         s_sync    <= {s_sync[1:0], bus.s_press};
         e_sync    <= {e_sync[1:0], bus.enter_press};
         cursor_q  <= cursor_d;
         mode_q    <= mode_d;
         hold_q    <= hold_d;
         start_q   <= start_d;
         in_menu_q <= in_menu_d;
      end
   end

   assign bus.cursor      = cursor_q;
   assign bus.mode        = mode_q;
   assign bus.start_pulse = start_q;
   assign bus.in_menu     = in_menu_q;
endmodule

// File: tb/tb_menu_select_fsm.sv
// Randomised key/game_over stimulus checked every cycle against a behavioural
// model of the menu controller.
module tb_menu_select_fsm;
   localparam int unsigned N_ITEMS       = 3;
   localparam int unsigned REPEAT_DELAY  = 20;
   localparam int unsigned REPEAT_PERIOD = 5;
   localparam int          NCYC          = 4000;

   logic clk = 1'b0;
   logic rst;

   menu_select_fsm_if #(.N_ITEMS(N_ITEMS)) bus ();

   menu_select_fsm #(
      .N_ITEMS      (N_ITEMS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Reference model: key levels seen by the controller are the inputs sampled
   // two edges earlier, and nothing sampled at or before a reset edge counts.
   typedef enum {M_MENU, M_WAIT, M_RUN} mstate_t;

   bit      samp [3][NCYC];   // 0=W, 1=S, 2=Enter, indexed by edge number
   int      last_rst;
   mstate_t m_st;
   int      m_cur, m_mode, m_since;
   bit      m_sp;

   function automatic bit held_at(input int k, input int n);
      if (n < 2 || (n - 2) <= last_rst) return 1'b0;
      return samp[k][n-2];
   endfunction

   function automatic int wrap_add(input int c, input int d);
      return (c + d + int'(N_ITEMS)) % int'(N_ITEMS);
   endfunction

   task automatic model_edge(input int n, input bit r, input bit w, input bit s,
                             input bit e, input bit go);
      bit wh, sh, eh, we, se, ee;
      samp[0][n] = w;
      samp[1][n] = s;
      samp[2][n] = e;
      if (r) begin
         last_rst = n;
         m_st = M_MENU; m_cur = 0; m_mode = 0; m_since = 0; m_sp = 0;
         return;
      end
      wh = held_at(0, n); sh = held_at(1, n); eh = held_at(2, n);
      we = wh && !held_at(0, n - 1);
      se = sh && !held_at(1, n - 1);
      ee = eh && !held_at(2, n - 1);
      m_sp = 0;
      case (m_st)
         M_MENU: begin
            if (ee) begin
               m_mode = m_cur; m_st = M_WAIT; m_since = 0;
            end else if (wh && sh) begin
               m_since = 0;
            end else if (we) begin
               m_cur = wrap_add(m_cur, -1); m_since = 0;
            end else if (se) begin
               m_cur = wrap_add(m_cur, 1); m_since = 0;
            end else if (wh || sh) begin
               m_since++;
               if (m_since == int'(REPEAT_DELAY) ||
                   (m_since > int'(REPEAT_DELAY) &&
                    (m_since - int'(REPEAT_DELAY)) % int'(REPEAT_PERIOD) == 0))
                  m_cur = wrap_add(m_cur, sh ? 1 : -1);
            end else begin
               m_since = 0;
            end
         end
         M_WAIT: begin
            m_since = 0;
            if (!eh) begin m_sp = 1; m_st = M_RUN; end
         end
         default: begin
            m_since = 0;
            if (go) begin m_cur = m_mode; m_st = M_MENU; end
         end
      endcase
   endtask

   // Segment-based key stimulus: each key pattern is followed by an idle gap
   int seg_left = 0;
   bit seg_gap  = 1'b1;
   bit seg_w, seg_s, seg_e;

   task automatic next_segment();
      int r;
      if (!seg_gap) begin
         seg_w = 0; seg_s = 0; seg_e = 0;
         seg_left = $urandom_range(1, 4);
         seg_gap = 1;
         return;
      end
      seg_gap = 0;
      seg_w = 0; seg_s = 0; seg_e = 0;
      r = $urandom_range(0, 9);
      case (r)
         0, 1, 2: begin seg_s = 1; seg_left = $urandom_range(1, 12); end
         3, 4:    begin seg_w = 1; seg_left = $urandom_range(1, 12); end
         5: begin
            if ($urandom_range(0, 1) == 0) seg_s = 1; else seg_w = 1;
            seg_left = $urandom_range(20, 45);
         end
         6: begin seg_w = 1; seg_s = 1; seg_left = $urandom_range(5, 30); end
         7: begin
            seg_e = 1; seg_s = 1'($urandom_range(0, 1));
            seg_left = $urandom_range(1, 10);
         end
         default: seg_left = $urandom_range(1, 6);
      endcase
   endtask

   initial begin
      rst = 1'b1;
      bus.w_press = 0; bus.s_press = 0; bus.enter_press = 0; bus.game_over = 0;
      last_rst = -10;
      m_st = M_MENU; m_cur = 0; m_mode = 0; m_since = 0; m_sp = 0;
      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk);
         model_edge(n, rst, bus.w_press, bus.s_press, bus.enter_press, bus.game_over);
         #1;
         check("cursor", 32'(bus.cursor), 32'(m_cur));
         check("mode", 32'(bus.mode), 32'(m_mode));
         check("start_pulse", 32'(bus.start_pulse), 32'(m_sp));
         check("in_menu", 32'(bus.in_menu), 32'(m_st != M_RUN));

         rst = (n < 1) || ($urandom_range(0, 399) == 0);
         bus.game_over = ($urandom_range(0, 11) == 0);
         if (seg_left == 0) next_segment();
         bus.w_press     = seg_w;
         bus.s_press     = seg_s;
         bus.enter_press = seg_e;
         seg_left--;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/menu_select_fsm.md
# menu_select_fsm

Menu navigation controller that sits directly downstream of the PS/2 keyboard decoder. It takes the decoder's level-style `w_press` / `s_press` / `enter_press` flags, which live in the `ps2_clk` domain. It synchronises them into the system clock domain and detects press edges. With hold-to-repeat, it moves a wrapping cursor over `N_ITEMS` menu entries, latches the chosen entry and issues a one-cycle start pulse to the game core. It returns to the menu when the game core signals `game_over`.

## Interface
Parameters:
- `N_ITEMS`, 3: number of menu entries; must be ≥ 2.
- `REPEAT_DELAY`, 50_000_000: clk cycles a W/S key must be held, counted from its first step, before auto-repeat begins.
- `REPEAT_PERIOD`, 15_000_000: clk cycles between auto-repeat steps; 1 ≤ `REPEAT_PERIOD` ≤ `REPEAT_DELAY`.
- `CW` (derived, not overridable): max(1, $clog2(`N_ITEMS`)).

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `w_press`  in  1  level flag, W held; asynchronous to `clk`.
- `s_press`  in  1  level flag, S held; asynchronous to `clk`.
- `enter_press`  in  1  level flag, Enter held; asynchronous to `clk`.
- `game_over`  in  1  one-cycle pulse from the game core, `clk` domain.
- `cursor`  out  CW  currently highlighted entry, 0..N_ITEMS-1.
- `mode`  out  CW  latched selected entry.
- `start_pulse`  out  1  one-cycle strobe when the game starts.
- `in_menu`  out  1  high while in the MENU or WAIT_REL state.

## Operation
- Synchronisers: each key input passes through a 2-flop synchroniser (d1, d2) followed by a history flop d3.
  - Press edge = d2 & ~d3.
  - Held = d2.
- States: MENU, WAIT_REL, RUN.
- MENU, evaluated in priority order:
  - Enter edge: `mode` <= `cursor`; go to WAIT_REL; no cursor move that cycle.
  - Otherwise, W edge with S not held: `cursor` steps up (decrement), wrapping 0 -> N_ITEMS-1.
  - Otherwise, S edge with W not held: `cursor` steps down (increment), wrapping N_ITEMS-1 -> 0.
  - W and S both held, or edges on both in the same cycle: no move; repeat counter cleared.
- Auto-repeat, MENU only:
  - `hold_cnt` (width $clog2(REPEAT_DELAY+1)) clears to 0 on a step caused by an edge.
  - It increments each cycle while exactly one of W/S is held.
  - When `hold_cnt` == REPEAT_DELAY, the cursor steps in the held direction and `hold_cnt` <= REPEAT_DELAY − REPEAT_PERIOD.
  - It clears on release, when both keys are held, or on leaving MENU.
- WAIT_REL: all keys are ignored. When synced Enter is low: `start_pulse` = 1 for exactly one cycle, go to RUN.
- RUN:
  - `in_menu` = 0; keys are ignored.
  - On `game_over`: `cursor` <= `mode`, go to MENU, `hold_cnt` cleared.
  - `game_over` in MENU or WAIT_REL is ignored.
- `mode` changes only on an Enter commit. It is stable throughout RUN.

## Timing
- Reset values, applied on the first `clk` edge with `rst`=1:
  - state MENU, `cursor`=0, `mode`=0, `start_pulse`=0, `in_menu`=1.
  - d1/d2/d3 = 0, `hold_cnt`=0.
- Reset applied mid-operation, in any state, forces these values on that edge. It overrides a simultaneous `game_over` or key edge.
- A key held across reset release produces a fresh press edge after synchronisation. This is intended and counts as a press.
- Key latency:
  - The input rises before clk edge 1; d1=1 after edge 1 and d2=1 after edge 2.
  - `cursor`, `mode` and the state update on edge 3.
  - A release is seen on edge 3 after it occurs.
- `start_pulse` is registered. It is high for the one cycle following the edge that leaves WAIT_REL, and `in_menu` falls on that same edge.
- Minimum time from Enter rise to `start_pulse` is Enter hold time + 3 cycles.
- `game_over` at edge k: `in_menu`=1 and `cursor`=`mode` after edge k. A key edge in that same cycle is ignored.
- Auto-repeat, with the first step at edge t0: repeat steps occur at t0+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- All outputs are registered; no combinational input-to-output path.

## Test plan
Use N_ITEMS=3, REPEAT_DELAY=20, REPEAT_PERIOD=5 unless noted.
- Reset, then pulse S for 10 cycles three times -> cursor 1, 2, 0 (wrap). Then one W pulse -> cursor 2. Each change lands on the 3rd edge after the input rises.
- Hold S for 40 cycles from cursor 0 -> steps at t0, t0+20, t0+25, t0+30, t0+35 -> cursor sequence 1, 2, 0, 1, 2. On release, hold_cnt returns to 0.
- Raise W and S on the same cycle, and hold both for 30 cycles -> cursor unchanged, no repeat steps.
- With cursor=2, hold Enter 8 cycles while also pulsing S -> mode=2, cursor stays 2, in_menu=1 during the hold. start_pulse is high for exactly 1 cycle 3 cycles after Enter falls, then in_menu=0.
- In RUN, toggle W/S/Enter -> no change to cursor/mode/start_pulse. Then pulse game_over -> in_menu=1 next cycle, cursor=mode=2.
- Assert rst for 1 cycle while in RUN with S held -> all outputs at reset values. Then the S edge after synchronisation moves cursor to 1 on the 3rd edge after rst drops.
